// File: rtl/dsp_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dsp_adder_pipe
// Brief    : Two-stage 32-bit carry-split adder with valid/ready handshake.
// Revision : 1.0
// ============================================================================
module dsp_adder_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  input  logic        carry_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        carry_out,
  output logic        overflow
);

  localparam int unsigned C_HALF = 16;

  logic              r_s1_valid;
  logic [C_HALF-1:0] r_lo;
  logic              r_c16;
  logic [C_HALF-1:0] r_a_hi;
  logic [C_HALF-1:0] r_b_hi;

  logic              r_out_valid;
  logic [31:0]       r_out;
  logic              r_carry_out;
  logic              r_overflow;

  logic              w_s2_load;
  logic              w_s1_load;
  logic [C_HALF:0]   w_lo_sum;
  logic [C_HALF:0]   w_hi_sum;
  logic              w_overflow;

  // Stage 1 may refill whenever it is empty or its occupant moves on this cycle.
  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = !r_s1_valid || !r_out_valid || out_ready;

  assign w_lo_sum = {1'b0, input1[C_HALF-1:0]} + {1'b0, input2[C_HALF-1:0]}
                  + {{C_HALF{1'b0}}, carry_in};
  assign w_hi_sum = {1'b0, r_a_hi} + {1'b0, r_b_hi} + {{C_HALF{1'b0}}, r_c16};

  // Operand sign bits live in the registered high halves.
  assign w_overflow = (r_a_hi[C_HALF-1] == r_b_hi[C_HALF-1]) &&
                      (w_hi_sum[C_HALF-1] != r_a_hi[C_HALF-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_lo       <= '0;
      r_c16      <= 1'b0;
      r_a_hi     <= '0;
      r_b_hi     <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_lo   <= w_lo_sum[C_HALF-1:0];
        r_c16  <= w_lo_sum[C_HALF];
        r_a_hi <= input1[31:C_HALF];
        r_b_hi <= input2[31:C_HALF];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out       <= {w_hi_sum[C_HALF-1:0], r_lo};
        r_carry_out <= w_hi_sum[C_HALF];
        r_overflow  <= w_overflow;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire
